// File: rtl/switch_port_driver_pkg.sv
// Shared types and sizing for the switch input-bus transmit agent.
package switch_pkg;

    localparam int NPORTS = 4;               // switch input ports
    localparam int DW     = 16;              // bus data width
    localparam int AW     = 16;              // bus address width
    localparam int DEPTH  = 4;               // words per port FIFO (power of 2, >= 2)
    localparam int PW     = $clog2(NPORTS);  // port index width
    localparam int WW     = AW + DW;         // packed word width

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } drv_state_e;

    // Address sits in the upper half so a word can be pushed as {addr, data}.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } word_t;

endpackage

// File: rtl/switch_port_driver_port_fifo.sv
// Per-port word FIFO.
// Pointers carry one extra MSB so that full and empty can be told apart
// without a separate occupancy counter. The head word is visible
// combinationally so the arbiter can load it on the same edge it pops.
module port_fifo
    import switch_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [WW-1:0] i_word,
    output logic [WW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PTRW = $clog2(DEPTH);

    logic [PTRW:0]   r_wr_ptr;
    logic [PTRW:0]   r_rd_ptr;
    logic [WW-1:0]   r_mem [DEPTH];
    logic            w_do_push;
    logic            w_do_pop;

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTRW] != r_rd_ptr[PTRW]) &&
                     (r_wr_ptr[PTRW-1:0] == r_rd_ptr[PTRW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[PTRW-1:0]];

    // Advance the read and write pointers; reset empties the FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTRW-1:0]] <= i_word;
    end

endmodule

// File: rtl/switch_port_driver.sv
// Transmit-side agent for the 4-port switch input bus.
// Upstream words are queued per target port, a round-robin arbiter picks the
// next non-empty queue, and the chosen word is held on the shared bus until
// the addressed switch port takes it. Back-to-back words need no idle cycle.
module switch_port_driver
    import switch_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_src_valid,
    input  logic [PW-1:0]     i_src_port,
    input  logic [DW-1:0]     i_src_data,
    input  logic [AW-1:0]     i_src_addr,
    output logic              o_src_ready,
    output logic [DW-1:0]     o_data_in,
    output logic [AW-1:0]     o_addr_in,
    output logic [NPORTS-1:0] o_valid_in,
    input  logic [NPORTS-1:0] i_rcv_rdy,
    output logic              o_busy,
    output logic [15:0]       o_tx_count
);

    // First requesting port strictly after 'last', wrapping; returns 'last'
    // itself only when it is the sole requester (or nobody requests).
    function automatic logic [PW-1:0] rr_pick(input logic [NPORTS-1:0] req,
                                              input logic [PW-1:0]     last);
        logic [PW-1:0] idx;
        rr_pick = last;
        for (int k = NPORTS; k >= 1; k--) begin
            idx = PW'((int'(last) + k) % NPORTS);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    drv_state_e        r_state;
    logic [PW-1:0]     r_last_grant;
    logic [NPORTS-1:0] r_valid_in;
    logic [DW-1:0]     r_data_in;
    logic [AW-1:0]     r_addr_in;
    logic [15:0]       r_tx_count;

    logic [NPORTS-1:0] w_empty;
    logic [NPORTS-1:0] w_full;
    logic [NPORTS-1:0] w_nonempty;
    logic [NPORTS-1:0] w_push;
    logic [NPORTS-1:0] w_pop;
    logic [WW-1:0]     w_head [NPORTS];
    logic [WW-1:0]     w_src_word;
    logic [WW-1:0]     w_grant_word;
    logic [PW-1:0]     w_grant;
    logic              w_xfer;
    logic              w_load;

    assign w_src_word   = {i_src_addr, i_src_data};
    assign w_nonempty   = ~w_empty;
    assign o_src_ready  = ~w_full[i_src_port];

    // Only the granted port's ready matters; valid_in is one-hot on last_grant in DRIVE.
    assign w_xfer       = (r_state == DRIVE) && i_rcv_rdy[r_last_grant];
    // Load a new word when the bus is free or is being freed on this edge.
    assign w_load       = (|w_nonempty) && ((r_state == IDLE) || w_xfer);
    assign w_grant      = rr_pick(w_nonempty, r_last_grant);
    assign w_grant_word = w_head[w_grant];

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign w_push[gi] = i_src_valid && o_src_ready && (i_src_port == PW'(gi));
            assign w_pop[gi]  = w_load && (w_grant == PW'(gi));

            port_fifo u_fifo (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_push  (w_push[gi]),
                .i_pop   (w_pop[gi]),
                .i_word  (w_src_word),
                .o_head  (w_head[gi]),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi])
            );
        end
    endgenerate

    // Bus FSM: grant, hold under backpressure, count transfers, chain words without a bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= PW'(NPORTS - 1);
            r_valid_in   <= '0;
            r_data_in    <= '0;
            r_addr_in    <= '0;
            r_tx_count   <= '0;
        end else begin
            if (w_xfer) r_tx_count <= r_tx_count + 16'd1;

            if (w_load) begin
                r_state      <= DRIVE;
                r_last_grant <= w_grant;
                r_valid_in   <= NPORTS'(1) << w_grant;
                r_data_in    <= w_grant_word[DW-1:0];
                r_addr_in    <= w_grant_word[WW-1:DW];
            end else if (w_xfer) begin
                // Nothing queued: drop valid, keep the last data/address on the bus.
                r_state    <= IDLE;
                r_valid_in <= '0;
            end
        end
    end

    assign o_valid_in = r_valid_in;
    assign o_data_in  = r_data_in;
    assign o_addr_in  = r_addr_in;
    assign o_busy     = (r_state == DRIVE);
    assign o_tx_count = r_tx_count;

endmodule

// File: tb/tb_switch_port_driver.sv
// Bench for switch_port_driver: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the port driver.
module tb_switch_port_driver;

    localparam int NP    = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        src_valid = 1'b0;
    logic [1:0]  src_port = '0;
    logic [15:0] src_data = '0;
    logic [15:0] src_addr = '0;
    logic        src_ready;
    logic [15:0] data_in;
    logic [15:0] addr_in;
    logic [3:0]  valid_in;
    logic [3:0]  rcv_rdy = '0;
    logic        busy;
    logic [15:0] tx_count;

    always #5 clk = ~clk;

    switch_port_driver dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_src_valid (src_valid),
        .i_src_port  (src_port),
        .i_src_data  (src_data),
        .i_src_addr  (src_addr),
        .o_src_ready (src_ready),
        .o_data_in   (data_in),
        .o_addr_in   (addr_in),
        .o_valid_in  (valid_in),
        .i_rcv_rdy   (rcv_rdy),
        .o_busy      (busy),
        .o_tx_count  (tx_count)
    );

    wire [52:0] dut_vec = {valid_in, busy, data_in, addr_in, tx_count};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per port plus the word currently on the bus.
    logic [31:0] q [NP][$];
    logic        m_busy;
    logic [3:0]  m_valid;
    logic [15:0] m_data;
    logic [15:0] m_addr;
    logic [15:0] m_cnt;
    int          m_last;

    function automatic logic [52:0] mvec();
        return {m_valid, m_busy, m_data, m_addr, m_cnt};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) q[p].delete();
        m_busy = 1'b0; m_valid = '0; m_data = '0; m_addr = '0; m_cnt = '0;
        m_last = NP - 1;
    endtask

    // Apply one clock edge to both the DUT and the model.
    task automatic tick();
        bit push_ok, xfer;
        int g;
        push_ok = src_valid && (q[src_port].size() < DEPTH);
        xfer    = m_busy && rcv_rdy[m_last];
        if (xfer) begin
            m_cnt++;
            $display("xfer port %0d data %h addr %h count %0d", m_last, m_data, m_addr, m_cnt);
        end
        if (!m_busy || xfer) begin
            g = -1;
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (m_last + k) % NP;
                if (g < 0 && q[p].size() > 0) g = p;
            end
            if (g >= 0) begin
                {m_addr, m_data} = q[g].pop_front();
                m_valid = 4'(1 << g);
                m_last  = g;
                m_busy  = 1'b1;
            end else begin
                m_busy  = 1'b0;
                m_valid = '0;
            end
        end
        if (push_ok) q[src_port].push_back({src_addr, src_data});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; src_valid = 1'b0; rcv_rdy = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec !== 53'h0) begin
            n_bad++; $display("FAIL reset_outputs got %h exp %h", dut_vec, 53'h0);
        end
        for (int p = 0; p < NP; p++) begin
            src_port = 2'(p);
            #1;
            n_cmp++;
            if (src_ready !== 1'b1) begin
                n_bad++; $display("FAIL reset_src_ready port %0d got %b exp 1", p, src_ready);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        src_valid = 1'b1; src_port = 2'd2; src_data = 16'hA5A5; src_addr = 16'h0003;
        rcv_rdy = 4'b0100;
        tick();
        src_valid = 1'b0;
        n_cmp++;
        if (valid_in !== 4'b0000) begin
            n_bad++; $display("FAIL single_early got %b exp 0000", valid_in);
        end
        tick();
        n_cmp++;
        if (dut_vec !== {4'b0100, 1'b1, 16'hA5A5, 16'h0003, 16'd0}) begin
            n_bad++; $display("FAIL single_offer got %h exp %h", dut_vec,
                              {4'b0100, 1'b1, 16'hA5A5, 16'h0003, 16'd0});
        end
        tick();
        n_cmp++;
        if (dut_vec !== {4'b0000, 1'b0, 16'hA5A5, 16'h0003, 16'd1}) begin
            n_bad++; $display("FAIL single_accept got %h exp %h", dut_vec,
                              {4'b0000, 1'b0, 16'hA5A5, 16'h0003, 16'd1});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        src_valid = 1'b1; src_port = 2'd2; src_data = 16'hA5A5; src_addr = 16'h0003;
        tick();
        src_valid = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            // Other ports' ready bits must be ignored while port 2 is driven.
            rcv_rdy = (i % 2 == 1) ? 4'b1011 : 4'b0000;
            tick();
            n_cmp++;
            if (dut_vec !== {4'b0100, 1'b1, 16'hA5A5, 16'h0003, 16'd0}) begin
                n_bad++; $display("FAIL bp_hold clk %0d got %h exp %h", i, dut_vec,
                                  {4'b0100, 1'b1, 16'hA5A5, 16'h0003, 16'd0});
            end
        end
        rcv_rdy = 4'b0100;
        tick();
        rcv_rdy = 4'b0000;
        repeat (2) tick();
        n_cmp++;
        if (dut_vec !== {4'b0000, 1'b0, 16'hA5A5, 16'h0003, 16'd1}) begin
            n_bad++; $display("FAIL bp_release got %h exp %h", dut_vec,
                              {4'b0000, 1'b0, 16'hA5A5, 16'h0003, 16'd1});
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < NP; p++) begin
            src_valid = 1'b1; src_port = 2'(p);
            src_data = 16'h1000 + 16'(p); src_addr = 16'(p);
            tick();
        end
        src_valid = 1'b0;
        n_cmp++;
        if (dut_vec !== {4'b0001, 1'b1, 16'h1000, 16'h0000, 16'd0}) begin
            n_bad++; $display("FAIL rr_first got %h exp %h", dut_vec,
                              {4'b0001, 1'b1, 16'h1000, 16'h0000, 16'd0});
        end
        rcv_rdy = 4'hF;
        for (int i = 1; i < NP; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== {4'(1 << i), 1'b1, 16'h1000 + 16'(i), 16'(i), 16'(i)}) begin
                n_bad++; $display("FAIL rr_step %0d got %h exp %h", i, dut_vec,
                                  {4'(1 << i), 1'b1, 16'h1000 + 16'(i), 16'(i), 16'(i)});
            end
        end
        tick();
        n_cmp++;
        if ({valid_in, busy, tx_count} !== {4'b0000, 1'b0, 16'd4}) begin
            n_bad++; $display("FAIL rr_done got %h exp %h", {valid_in, busy, tx_count},
                              {4'b0000, 1'b0, 16'd4});
        end
    endtask

    task automatic test_full();
        logic [31:0] sent [$];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            src_valid = 1'b1; src_port = 2'd1;
            src_data = 16'($urandom); src_addr = 16'($urandom);
            #1;
            n_cmp++;
            if (src_ready !== 1'b1) begin
                n_bad++; $display("FAIL full_fill_ready word %0d got %b exp 1", i, src_ready);
            end
            sent.push_back({src_addr, src_data});
            tick();
        end
        src_data = 16'hBEEF; src_addr = 16'hDEAD;
        #1;
        n_cmp++;
        if (src_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_ready_p1 got %b exp 0", src_ready);
        end
        src_port = 2'd0;
        #1;
        n_cmp++;
        if (src_ready !== 1'b1) begin
            n_bad++; $display("FAIL full_ready_p0 got %b exp 1", src_ready);
        end
        n_cmp++;
        if ({addr_in, data_in} !== sent[0]) begin
            n_bad++; $display("FAIL full_order word 0 got %h exp %h", {addr_in, data_in}, sent[0]);
        end
        // Push to the full port coincides with a pop; it must still be refused.
        src_port = 2'd1;
        rcv_rdy = 4'b0010;
        for (int i = 1; i < 5; i++) begin
            tick();
            src_valid = 1'b0;
            n_cmp++;
            if ({valid_in, addr_in, data_in} !== {4'b0010, sent[i]}) begin
                n_bad++; $display("FAIL full_order word %0d got %h exp %h", i,
                                  {valid_in, addr_in, data_in}, {4'b0010, sent[i]});
            end
        end
        repeat (2) tick();
        n_cmp++;
        if ({valid_in, tx_count} !== {4'b0000, 16'd5}) begin
            n_bad++; $display("FAIL full_drain got %h exp %h", {valid_in, tx_count}, {4'b0000, 16'd5});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            src_valid = 1'b1; src_port = 2'd3;
            src_data = 16'($urandom); src_addr = 16'($urandom);
            tick();
        end
        src_valid = 1'b0;
        n_cmp++;
        if (valid_in !== 4'b1000) begin
            n_bad++; $display("FAIL areset_setup got %b exp 1000", valid_in);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 53'h0) begin
            n_bad++; $display("FAIL areset_immediate got %h exp %h", dut_vec, 53'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rcv_rdy = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== 53'h0) begin
                n_bad++; $display("FAIL areset_empty clk %0d got %h exp %h", i, dut_vec, 53'h0);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            src_valid = ($urandom % 3) != 0;
            src_port  = 2'($urandom);
            src_data  = 16'($urandom);
            src_addr  = 16'($urandom);
            rcv_rdy   = (c % 80 < 30) ? 4'($urandom & $urandom) : 4'($urandom);
            #1;
            n_cmp++;
            if (src_ready !== (q[src_port].size() < DEPTH)) begin
                n_bad++; $display("FAIL rand_ready clk %0d port %0d got %b exp %b", c, src_port,
                                  src_ready, q[src_port].size() < DEPTH);
            end
            tick();
            n_cmp++;
            if (dut_vec !== mvec()) begin
                n_bad++; $display("FAIL rand_outputs clk %0d got %h exp %h", c, dut_vec, mvec());
            end
            n_cmp++;
            if (!$onehot0(valid_in)) begin
                n_bad++; $display("FAIL rand_onehot clk %0d got %b exp onehot0", c, valid_in);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_full();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
